instr_fetch: RTL and testbench

- Instruction fetch unit: the producer of the 32-bit IR word that the instruction decoder/controller consumes.
- Owns the PC and runs a request/acknowledge handshake with instruction memory.
- Presents one IR at a time with a valid/ready handshake.
- Takes redirect information back from the decode/execute side (Jump from the controller, branch outcome from the comparator) to pick the next PC.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_fetch_if.sv | 24 ++
 rtl/pc_next_calc.sv | 26 ++
 rtl/instr_fetch.sv | 109 ++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch definitions: FSM state encoding, instruction field widths, PC step.
// Optional performance counters in instr_fetch are enabled by defining IFETCH_PERF_EN.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HOLD = 2'b01,
    S_ERR  = 2'b10
  } state_t;

  localparam int OP_MSB = 31;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OP_MSB -: 6];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack side and IR valid/ready side.
// IR transfer: a word moves when ir_valid && ir_ready at a rising edge; IR/ir_pc hold while ir_valid && !ir_ready.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] IR;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        jump;
  logic        branch_taken;

  modport master (
    output imem_req, imem_addr, ir_valid, IR, ir_pc,
    input  imem_ack, imem_rdata, ir_ready, jump, branch_taken
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, IR, ir_pc,
    output imem_ack, imem_rdata, ir_ready, jump, branch_taken
  );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection from the held instruction: jump beats branch beats pc+4.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0] ir_pc,
  input  logic [31:0] ir,
  input  logic        jump,
  input  logic        branch_taken,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign pc4           = ir_pc + PC_STEP;
  assign jump_target   = {pc4[31:28], ir[JIDX_W-1:0], 2'b00};
  assign branch_target = pc4 + {{14{ir[IMM_W-1]}}, ir[IMM_W-1:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, one outstanding imem request, presents one IR at a time.
// Define IFETCH_PERF_EN to add fetch_cnt / stall_cnt performance counters.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  instr_fetch_if.master bus,
  output logic        fetch_err,
  output state_t      dbg_state
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [15:0] TMO_LAST = 16'(IMEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        run;
  logic [31:0] pc;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  logic [15:0] tmo_cnt;
  logic [31:0] next_pc;
  logic        req_active, ack_take, req_miss, accept, tmo_hit;

  // run holds the request off for the first cycle out of reset, so a stale ack there is dropped.
  assign req_active = run && (state == S_REQ);
  assign ack_take   = req_active && bus.imem_ack;
  assign req_miss   = req_active && !bus.imem_ack;
  assign accept     = (state == S_HOLD) && bus.ir_ready;
  assign tmo_hit    = req_miss && (tmo_cnt == TMO_LAST);

  pc_next_calc u_pc_next_calc (
    .ir_pc        (ir_pc_q),
    .ir           (ir_q),
    .jump         (bus.jump),
    .branch_taken (bus.branch_taken),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (ack_take)     state_nxt = S_HOLD;
        else if (tmo_hit) state_nxt = S_ERR;
      end
      S_HOLD:  if (bus.ir_ready) state_nxt = S_REQ;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    bus.imem_req  = req_active;
    bus.imem_addr = pc;
    bus.ir_valid  = (state == S_HOLD);
    bus.IR        = ir_q;
    bus.ir_pc     = ir_pc_q;
    dbg_state     = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      pc        <= RESET_PC;
      ir_q      <= 32'h0;
      ir_pc_q   <= 32'h0;
      tmo_cnt   <= 16'h0;
      fetch_err <= 1'b0;
    end else begin
      run <= 1'b1;
      if (ack_take) begin
        ir_q    <= bus.imem_rdata;
        ir_pc_q <= pc;
        tmo_cnt <= 16'h0;
      end else if (req_miss) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end
      if (accept)  pc        <= next_pc;
      if (tmo_hit) fetch_err <= 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (req_miss || ((state == S_HOLD) && !bus.ir_ready))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: imem responder tasks, IR scoreboard queue, redirect and timeout checks.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_err;
  state_t dbg_state;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .fetch_err (fetch_err),
    .dbg_state (dbg_state)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  // Waits (bounded) for a request, checks address, acks one cycle later, then scoreboards the IR.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    int waited = 0;
    logic [63:0] exp;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 64'(bus.imem_req), 64'd1);
    check("req_addr", 64'(bus.imem_addr), 64'(exp_addr));
    @(negedge clk);
    check("addr_stable", 64'(bus.imem_addr), 64'(exp_addr));
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    exp_q.push_back({data, exp_addr});
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    check("ir_valid", 64'(bus.ir_valid), 64'd1);
    if (bus.ir_valid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("ir_word", {bus.IR, bus.ir_pc}, exp);
    end
  endtask

  task automatic accept(input logic j, input logic b, input logic [31:0] exp_next);
    bus.ir_ready = 1'b1;
    bus.jump = j;
    bus.branch_taken = b;
    @(negedge clk);
    bus.ir_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    check("post_accept_valid", 64'(bus.ir_valid), 64'd0);
    check("next_req", 64'(bus.imem_req), 64'd1);
    check("next_addr", 64'(bus.imem_addr), 64'(exp_next));
  endtask

  initial begin
    int req_cycles;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.ir_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_valid", 64'(bus.ir_valid), 64'd0);
    check("rst_ir", 64'(bus.IR), 64'd0);
    check("rst_ir_pc", 64'(bus.ir_pc), 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_REQ));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 64'(bus.imem_req), 64'd1);
    check("first_addr", 64'(bus.imem_addr), 64'h0);

    fetch(32'h0000_0000, 32'h2008_0005);
    accept(1'b0, 1'b0, 32'h0000_0004);
    fetch(32'h0000_0004, 32'h0810_0000);
    accept(1'b1, 1'b0, 32'h0040_0000);
    fetch(32'h0040_0000, 32'h0800_0010);
    accept(1'b1, 1'b0, 32'h0000_0040);
    fetch(32'h0000_0040, 32'h0800_0040);
    accept(1'b1, 1'b0, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h1000_FFFF);
    accept(1'b0, 1'b1, 32'h0000_0100);

    // Back-pressure with redirects presented but not accepted, then both redirects: jump wins.
    fetch(32'h0000_0100, 32'h0C00_0020);
    bus.jump = 1'b1;
    bus.branch_taken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ir", {bus.IR, bus.ir_pc}, {32'h0C00_0020, 32'h0000_0100});
      check("bp_req", 64'(bus.imem_req), 64'd0);
      check("bp_valid", 64'(bus.ir_valid), 64'd1);
    end
    accept(1'b1, 1'b1, 32'h0000_0080);

    fetch(32'h0000_0080, 32'h1000_FFDE);
    accept(1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0000);
    accept(1'b0, 1'b0, 32'h0000_0000);
`ifdef IFETCH_PERF_EN
    check("fetch_cnt", 64'(fetch_cnt), 64'd8);
`endif

    // Reset while a request is pending, stray ack in the first cycle after release.
    rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(bus.imem_req), 64'd0);
    check("midrst_valid", 64'(bus.ir_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    check("restart_req", 64'(bus.imem_req), 64'd1);
    check("restart_addr", 64'(bus.imem_addr), 64'h0);
    check("stray_ack_valid", 64'(bus.ir_valid), 64'd0);
    @(negedge clk);
    check("stray_ack_ir", 64'(bus.IR), 64'd0);
    fetch(32'h0000_0000, 32'h2008_0005);
    accept(1'b0, 1'b0, 32'h0000_0004);

    // Timeout from a clean restart: count request cycles until the error flag sets.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fetch_err === 1'b1) break;
      if (bus.imem_req === 1'b1) req_cycles++;
    end
    check("tmo_req_cycles", 64'(req_cycles), 64'd16);
    check("tmo_err", 64'(fetch_err), 64'd1);
    check("tmo_req", 64'(bus.imem_req), 64'd0);
    check("tmo_state", 64'(dbg_state), 64'(S_ERR));
    bus.imem_ack = 1'b1;
    bus.ir_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.ir_ready = 1'b0;
    check("err_stuck", {62'd0, fetch_err, bus.ir_valid}, 64'd2);
    check("err_stuck_state", 64'(dbg_state), 64'(S_ERR));
    rst_n = 1'b0;
    #1;
    check("err_cleared", 64'(fetch_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("err_restart_req", 64'(bus.imem_req), 64'd1);
    check("err_restart_addr", 64'(bus.imem_addr), 64'h0);
    fetch(32'h0000_0000, 32'h1234_5678);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
